hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline interlock for the five-stage processor: sits beside the decode/execute boundary, upstream of the execute-stage bypass muxes. Detects load-use hazards that forwarding cannot cover and inserts one bubble. Sequences multicycle mul/div in execute through a handshake with the multdiv unit, freezing the front end until the result returns. Its freeze/bubble outputs drive the PC, F/D and D/X latch enables, and the D/X and X/M nop muxes.

## Interface
- `TIMEOUT_CYCLES`, 40: cycles allowed in WAIT before abort (used only with `MULTDIV_TIMEOUT_EN`).
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `FDIR`  in  32: instruction in F/D latch.
- `DXIR`  in  32: instruction in D/X latch.
- `flush`  in  1: taken branch/jump from execute; squashes F/D and D/X this cycle.
- `data_resultRDY`  in  1: multdiv result valid, single-cycle pulse.
- `data_result`  in  32: multdiv result.
- `stall_fd`  out  1: hold PC and F/D.
- `stall_dx`  out  1: hold D/X.
- `nop_dx`  out  1: load zero into D/X.
- `nop_xm`  out  1: load zero into X/M.
- `ctrl_mult`, `ctrl_div`  out  1: one-cycle start pulses to multdiv.
- `md_result`  out  32: registered multdiv result.
- `md_result_valid`  out  1: execute selects `md_result` instead of ALU output.
- `md_timeout`  out  1: sticky abort flag (with `MULTDIV_TIMEOUT_EN` only; else tied 0).

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]. Opcodes: 0 R-type, 2 bne, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw. ALU op 6 = mul, 7 = div.
- Load-use, combinational: DX opcode 8, DX rd != 0, and FD reads DX rd. FD reads: R-type rs, rt; addi/lw/sw rs; bne/blt rd, rs; jr rd. sw data (rd) is NOT a hazard, because memory-stage bypass covers it. Response: `stall_fd`=1, `nop_dx`=1 for exactly one cycle.
- Multdiv FSM, states IDLE, WAIT, DONE:
  - IDLE: DX is R-type mul/div → assert `ctrl_mult`/`ctrl_div` combinationally, `stall_fd`=`stall_dx`=`nop_xm`=1, go WAIT.
  - WAIT: same stalls, no ctrl pulse. On `data_resultRDY`, capture `data_result` into `md_result` and go DONE.
  - DONE: stalls released, `md_result_valid`=1, DX advances into X/M, go IDLE.
- Priority: multdiv stall overrides load-use. When both fire, `nop_dx`=0 and the load-use check re-evaluates after release.
- `flush`=1: load-use outputs forced 0. Multdiv FSM unaffected, because a mul/div in DX is older than the flushing branch.
- `data_resultRDY` outside WAIT is ignored.

## Timing
- Reset (`reset`=0 at edge): state IDLE, `md_result`=0, `md_timeout`=0. All outputs 0 the following cycle. Reset mid-WAIT abandons the operation with no ctrl pulse.
- Load-use bubble costs 1 cycle.
- mul/div enters DX at cycle t with RDY arriving at t+k (k≥1): stalls asserted t..t+k, DONE at t+k+1, so the total freeze is k+1 cycles.
- Back-to-back mul then div: div reaches DX in the cycle after DONE and gets a fresh IDLE→WAIT with a new pulse. There is never a double pulse for one instruction.
- Outputs are combinational from state plus IRs; only state, counter and `md_result` are registered.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes DONE with `md_result`=0 and `md_timeout` set sticky until reset.
- Undefined: no counter, WAIT is unbounded, and `md_timeout` is tied 0.

## Structure
- Shared `pipeline_pkg`:
  - opcode constants
  - ALU-op constants for mul/div
  - IR field-slice localparams
  - FSM state enum
- One sub-module, `multdiv_handshake`: the FSM, optional counter and result register. The top level holds load-use decode and priority logic.

## Test plan
- DX = lw r3; FD = add r4,r3,r5 → `stall_fd`=`nop_dx`=1 for one cycle, then 0.
- DX = lw r3; FD = sw r3,0(r6) → no stall. DX = lw r0; FD = add r4,r0,r0 → no stall.
- DX = mul r1,r2,r3; RDY after 32 cycles with 0x0000_0006 → `ctrl_mult` high exactly one cycle, stalls 33 cycles, `md_result`=6 with valid in the DONE cycle.
- mul in DX while FD = add reading lw result in DX → multdiv stall only, `nop_dx`=0; after DONE no spurious bubble.
- Reset low during WAIT → IDLE next cycle, all outputs 0; a late RDY is ignored.
- `MULTDIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=40, no RDY → DONE after 40 WAIT cycles, `md_timeout`=1 persists until reset.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, ALU ops, instruction field positions,
// the multdiv FSM state type and the register-read decode helper.
package pipeline_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;

    localparam logic [4:0] ALU_MUL  = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // True when an instruction with these fields reads register r as a source
    // that must come from the load. sw data (rd) is covered by the memory bypass.
    function automatic logic reads_reg(input logic [4:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] r);
        logic hit;
        hit = 1'b0;
        case (opc)
            OP_RTYPE:              hit = (rs == r) || (rt == r);
            OP_ADDI, OP_LW, OP_SW: hit = (rs == r);
            OP_BNE, OP_BLT:        hit = (rd == r) || (rs == r);
            OP_JR:                 hit = (rd == r);
            default:               hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_multdiv_handshake.sv
// Multdiv handshake FSM (IDLE/WAIT/DONE) with result register.
// Optional WAIT watchdog enabled by MULTDIV_TIMEOUT_EN.
module multdiv_handshake
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start_mult,
    input  logic        i_start_div,
    input  logic        i_rdy,
    input  logic [31:0] i_result,
    output logic        o_stall,
    output logic        o_ctrl_mult,
    output logic        o_ctrl_div,
    output logic [31:0] o_md_result,
    output logic        o_md_valid,
    output logic        o_md_timeout
);

    md_state_t   r_state;
    md_state_t   w_state_next;
    logic [31:0] r_md_result;
    logic        w_capture;
    logic        w_expire;
    logic        w_timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Counter is zero on WAIT entry, so expiry lands on the last allowed WAIT cycle.
    always_ff @(posedge clock) begin
        if (!reset || (r_state != MD_WAIT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign w_expire     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_md_timeout = r_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_expire     = 1'b0;
    assign o_md_timeout = 1'b0;
`endif

    assign w_timeout_hit = (r_state == MD_WAIT) && !i_rdy && w_expire;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= MD_IDLE;
            r_md_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_md_result <= i_result;
            end else if (w_timeout_hit) begin
                r_md_result <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_ctrl_mult  = 1'b0;
        o_ctrl_div   = 1'b0;
        o_md_valid   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start_mult || i_start_div) begin
                    o_stall      = 1'b1;
                    o_ctrl_mult  = i_start_mult;
                    o_ctrl_div   = i_start_div;
                    w_state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                o_stall = 1'b1;
                if (i_rdy) begin
                    w_capture    = 1'b1;
                    w_state_next = MD_DONE;
                end else if (w_expire) begin
                    w_state_next = MD_DONE;
                end
            end
            MD_DONE: begin
                o_md_valid   = 1'b1;
                w_state_next = MD_IDLE;
            end
            default: w_state_next = MD_IDLE;
        endcase
        // Held reset keeps the interlock quiet so an abandoned op cannot re-pulse.
        if (!reset) begin
            o_stall     = 1'b0;
            o_ctrl_mult = 1'b0;
            o_ctrl_div  = 1'b0;
            o_md_valid  = 1'b0;
        end
    end

    assign o_md_result = r_md_result;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode/execute interlock: load-use bubble insertion plus multdiv freeze.
// Build option MULTDIV_TIMEOUT_EN enables the multdiv WAIT watchdog.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FDIR,
    input  logic [31:0] DXIR,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic [31:0] data_result,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        nop_dx,
    output logic        nop_xm,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_result,
    output logic        md_result_valid,
    output logic        md_timeout
);

    logic [4:0] w_fd_opc;
    logic [4:0] w_fd_rd;
    logic [4:0] w_fd_rs;
    logic [4:0] w_fd_rt;
    logic [4:0] w_dx_opc;
    logic [4:0] w_dx_rd;
    logic [4:0] w_dx_aluop;
    logic       w_start_mult;
    logic       w_start_div;
    logic       w_load_use;
    logic       w_lu_active;
    logic       w_md_stall;
    logic       w_unused_ir;

    assign w_fd_opc   = FDIR[OPC_HI:OPC_LO];
    assign w_fd_rd    = FDIR[RD_HI:RD_LO];
    assign w_fd_rs    = FDIR[RS_HI:RS_LO];
    assign w_fd_rt    = FDIR[RT_HI:RT_LO];
    assign w_dx_opc   = DXIR[OPC_HI:OPC_LO];
    assign w_dx_rd    = DXIR[RD_HI:RD_LO];
    assign w_dx_aluop = DXIR[ALUOP_HI:ALUOP_LO];

    assign w_unused_ir = ^{FDIR[RT_LO-1:0], DXIR[RS_HI:ALUOP_HI+1], DXIR[ALUOP_LO-1:0]};

    assign w_start_mult = (w_dx_opc == OP_RTYPE) && (w_dx_aluop == ALU_MUL);
    assign w_start_div  = (w_dx_opc == OP_RTYPE) && (w_dx_aluop == ALU_DIV);

    // r0 never carries a real load value, so a load into r0 cannot create a hazard.
    assign w_load_use = (w_dx_opc == OP_LW) && (w_dx_rd != 5'd0) &&
                        reads_reg(w_fd_opc, w_fd_rd, w_fd_rs, w_fd_rt, w_dx_rd);
    assign w_lu_active = reset && w_load_use && !flush;

    multdiv_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_multdiv_handshake (
        .clock        (clock),
        .reset        (reset),
        .i_start_mult (w_start_mult),
        .i_start_div  (w_start_div),
        .i_rdy        (data_resultRDY),
        .i_result     (data_result),
        .o_stall      (w_md_stall),
        .o_ctrl_mult  (ctrl_mult),
        .o_ctrl_div   (ctrl_div),
        .o_md_result  (md_result),
        .o_md_valid   (md_result_valid),
        .o_md_timeout (md_timeout)
    );

    // Multdiv freeze wins; a pending load-use is re-evaluated once it releases.
    assign stall_fd = w_md_stall || w_lu_active;
    assign stall_dx = w_md_stall;
    assign nop_dx   = w_lu_active && !w_md_stall;
    assign nop_xm   = w_md_stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (timeout case needs MULTDIV_TIMEOUT_EN).
module tb_hazard_stall_unit;

    logic        clock;
    logic        reset;
    logic [31:0] FDIR;
    logic [31:0] DXIR;
    logic        flush;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        stall_fd;
    logic        stall_dx;
    logic        nop_dx;
    logic        nop_xm;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] md_result;
    logic        md_result_valid;
    logic        md_timeout;

    int n_pass  = 0;
    int n_total = 0;

    // {stall_fd, stall_dx, nop_dx, nop_xm, ctrl_mult, ctrl_div, md_result_valid, md_timeout}
    logic [7:0] outs;
    assign outs = {stall_fd, stall_dx, nop_dx, nop_xm, ctrl_mult, ctrl_div, md_result_valid, md_timeout};

    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1010_0000;
    localparam logic [7:0] E_MUL  = 8'b1101_1000;
    localparam logic [7:0] E_DIV  = 8'b1101_0100;
    localparam logic [7:0] E_WAIT = 8'b1101_0000;
    localparam logic [7:0] E_DONE = 8'b0000_0010;

    hazard_stall_unit #(
        .TIMEOUT_CYCLES (40)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .FDIR            (FDIR),
        .DXIR            (DXIR),
        .flush           (flush),
        .data_resultRDY  (data_resultRDY),
        .data_result     (data_result),
        .stall_fd        (stall_fd),
        .stall_dx        (stall_dx),
        .nop_dx          (nop_dx),
        .nop_xm          (nop_xm),
        .ctrl_mult       (ctrl_mult),
        .ctrl_div        (ctrl_div),
        .md_result       (md_result),
        .md_result_valid (md_result_valid),
        .md_timeout      (md_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int stalls;
        int pulses;

        reset = 1'b0; FDIR = '0; DXIR = '0; flush = 1'b0;
        data_resultRDY = 1'b0; data_result = '0;

        // Reset
        cyc;
        #1 chk("reset_held_outs", 32'(outs), 32'(E_NONE));
        cyc;
        reset = 1'b1;
        #1 chk("reset_outs", 32'(outs), 32'(E_NONE));
        chk("reset_md_result", md_result, 32'd0);

        // Load-use: lw r3 then add r4,r3,r5 -> one bubble
        cyc;
        DXIR = itype(5'd8, 5'd3, 5'd1); FDIR = rtype(5'd4, 5'd3, 5'd5, 5'd0);
        #1 chk("lu_add_rs", 32'(outs), 32'(E_LU));
        cyc;
        DXIR = '0;
        #1 chk("lu_after_bubble", 32'(outs), 32'(E_NONE));
        cyc;
        DXIR = itype(5'd8, 5'd3, 5'd1); FDIR = rtype(5'd4, 5'd5, 5'd3, 5'd0);
        #1 chk("lu_add_rt", 32'(outs), 32'(E_LU));
        flush = 1'b1;
        #1 chk("lu_flush", 32'(outs), 32'(E_NONE));
        flush = 1'b0;
        FDIR = itype(5'd7, 5'd3, 5'd6);
        #1 chk("lu_sw_data", 32'(outs), 32'(E_NONE));
        FDIR = itype(5'd7, 5'd6, 5'd3);
        #1 chk("lu_sw_base", 32'(outs), 32'(E_LU));
        FDIR = itype(5'd2, 5'd3, 5'd7);
        #1 chk("lu_bne_rd", 32'(outs), 32'(E_LU));
        FDIR = itype(5'd4, 5'd3, 5'd0);
        #1 chk("lu_jr_rd", 32'(outs), 32'(E_LU));
        FDIR = itype(5'd4, 5'd5, 5'd0);
        #1 chk("lu_jr_other", 32'(outs), 32'(E_NONE));
        FDIR = itype(5'd5, 5'd4, 5'd3);
        #1 chk("lu_addi_rs", 32'(outs), 32'(E_LU));
        DXIR = itype(5'd8, 5'd0, 5'd1); FDIR = rtype(5'd4, 5'd0, 5'd0, 5'd0);
        #1 chk("lu_r0", 32'(outs), 32'(E_NONE));

        // mul r1,r2,r3 with result after 32 cycles; FD reads r1
        cyc;
        DXIR = rtype(5'd1, 5'd2, 5'd3, 5'd6); FDIR = rtype(5'd4, 5'd1, 5'd5, 5'd0);
        #1 chk("mul_start", 32'(outs), 32'(E_MUL));
        stalls = stall_fd ? 1 : 0;
        pulses = ctrl_mult ? 1 : 0;
        for (int i = 1; i <= 32; i++) begin
            cyc;
            data_resultRDY = (i == 32);
            data_result = 32'h0000_0006;
            #1;
            if (stall_fd && stall_dx && nop_xm && !nop_dx) stalls++;
            if (ctrl_mult) pulses++;
        end
        cyc;
        data_resultRDY = 1'b0; data_result = 32'hFFFF_FFFF;
        #1 chk("mul_stall_cycles", 32'(stalls), 32'd33);
        chk("mul_pulse_count", 32'(pulses), 32'd1);
        chk("mul_done_outs", 32'(outs), 32'(E_DONE));
        chk("mul_done_result", md_result, 32'd6);
        cyc;
        DXIR = '0;
        #1 chk("mul_after_done", 32'(outs), 32'(E_NONE));

        // div with an RDY in IDLE (ignored), then RDY in DONE (ignored)
        cyc;
        DXIR = rtype(5'd2, 5'd4, 5'd5, 5'd7); FDIR = rtype(5'd6, 5'd2, 5'd0, 5'd0);
        data_resultRDY = 1'b1; data_result = 32'h0000_0BAD;
        #1 chk("div_start", 32'(outs), 32'(E_DIV));
        cyc;
        data_resultRDY = 1'b0;
        #1 chk("div_wait", 32'(outs), 32'(E_WAIT));
        chk("div_idle_rdy_ignored", md_result, 32'd6);
        cyc;
        data_resultRDY = 1'b1; data_result = 32'h0000_0015;
        #1 chk("div_wait_rdy", 32'(outs), 32'(E_WAIT));
        cyc;
        data_result = 32'h0000_0077;
        #1 chk("div_done_outs", 32'(outs), 32'(E_DONE));
        chk("div_done_result", md_result, 32'h15);

        // Back-to-back mul gets a fresh pulse
        cyc;
        data_resultRDY = 1'b0;
        DXIR = rtype(5'd7, 5'd1, 5'd1, 5'd6);
        #1 chk("b2b_mul_start", 32'(outs), 32'(E_MUL));
        chk("done_rdy_ignored", md_result, 32'h15);
        cyc;
        data_resultRDY = 1'b1; data_result = 32'h0000_0022;
        #1 chk("b2b_mul_wait", 32'(outs), 32'(E_WAIT));
        cyc;
        data_resultRDY = 1'b0;
        #1 chk("b2b_mul_done", 32'(outs), 32'(E_DONE));
        chk("b2b_mul_result", md_result, 32'h22);
        cyc;
        DXIR = '0; FDIR = '0;
        #1 chk("b2b_idle", 32'(outs), 32'(E_NONE));

        // Reset in the middle of WAIT
        cyc;
        DXIR = rtype(5'd1, 5'd2, 5'd3, 5'd6);
        #1 chk("rst_mul_start", 32'(outs), 32'(E_MUL));
        cyc;
        #1 chk("rst_mul_wait", 32'(outs), 32'(E_WAIT));
        reset = 1'b0; DXIR = '0;
        #1 chk("rst_held", 32'(outs), 32'(E_NONE));
        cyc;
        reset = 1'b1;
        #1 chk("rst_after_outs", 32'(outs), 32'(E_NONE));
        chk("rst_after_result", md_result, 32'd0);
        cyc;
        data_resultRDY = 1'b1; data_result = 32'h0000_0099;
        #1 chk("rst_late_rdy_outs", 32'(outs), 32'(E_NONE));
        cyc;
        data_resultRDY = 1'b0;
        #1 chk("rst_late_rdy_result", md_result, 32'd0);
        chk("rst_late_rdy_idle", 32'(outs), 32'(E_NONE));

`ifdef MULTDIV_TIMEOUT_EN
        // No RDY: 40 WAIT cycles then DONE with timeout
        cyc;
        DXIR = rtype(5'd1, 5'd2, 5'd3, 5'd6);
        #1 chk("to_start", 32'(outs), 32'(E_MUL));
        stalls = 1;
        for (int i = 1; i <= 40; i++) begin
            cyc;
            #1;
            if (stall_fd) stalls++;
        end
        cyc;
        #1 chk("to_stall_cycles", 32'(stalls), 32'd41);
        chk("to_done_outs", 32'(outs), 32'b0000_0011);
        chk("to_done_result", md_result, 32'd0);
        cyc;
        DXIR = '0;
        #1 chk("to_sticky", 32'(outs), 32'b0000_0001);
        cyc;
        #1 chk("to_sticky_2", 32'(md_timeout), 32'd1);
        reset = 1'b0;
        cyc;
        reset = 1'b1;
        #1 chk("to_cleared", 32'(md_timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
